// File: rtl/manchester_xmit.sv
// manchester_xmit
//   Byte serializer that Manchester-encodes each accepted byte LSB-first onto
//   txd. A holding register plus the shift register let back-to-back bytes
//   go out with no idle gap on the line.
//
//   Encoding: bit 0 -> first half 1, second half 0
//             bit 1 -> first half 0, second half 1
//
//   Optional feature macro: MX_EOF_EN
//     defined   : after the final byte, txd is held high with txen=1 for
//                 EOF_BITS bit times before the line goes idle.
//     undefined : no EOF hold; txen drops the cycle after the last half-bit.
//
//   Ports
//     clk    in   system clock
//     rst    in   synchronous, active-high reset
//     data   in   [7:0] byte to send, sampled when valid && rdy
//     valid  in   upstream byte valid
//     rdy    out  holding register empty (byte accepted this cycle if valid)
//     txd    out  registered Manchester line output (idles high)
//     txen   out  registered transmitter enable
//     busy   out  FSM not idle, or holding register full
module manchester_xmit #(
   parameter int CLKS_PER_HALFBIT = 50,
   parameter int EOF_BITS         = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       rdy,
   output logic       txd,
   output logic       txen,
   output logic       busy
);

   localparam int HCW = $clog2(CLKS_PER_HALFBIT);
   localparam logic [HCW-1:0] HC_LAST = HCW'(CLKS_PER_HALFBIT - 1);

`ifdef MX_EOF_EN
   localparam int EOF_CYCLES = EOF_BITS * 2 * CLKS_PER_HALFBIT;
   localparam int ECW = $clog2(EOF_CYCLES + 1);
   localparam logic [ECW-1:0] EOF_LAST = ECW'(EOF_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_EOF} state_t;
`else
   typedef enum logic {ST_IDLE, ST_SEND} state_t;
`endif

   state_t           state_q;
   logic [7:0]       hold_q;
   logic             hold_full_q;
   logic             hold_full_d;
   logic [7:0]       shift_q;
   logic [HCW-1:0]   hcnt_q;
   logic [2:0]       bit_q;
   logic             half_q;
   logic             txd_q;
   logic             txen_q;
`ifdef MX_EOF_EN
   logic [ECW-1:0]   eof_cnt_q;
`endif

   logic accept;
   logic half_end;
   logic byte_end;
   logic load;

   always_comb begin
      accept   = valid && !hold_full_q;
      half_end = (hcnt_q == HC_LAST);
      byte_end = (state_q == ST_SEND) && half_end && half_q && (bit_q == 3'd7);
      // Hold drains into the shift register either from idle or exactly at
      // the last clock of the current byte, which keeps the line gap-free.
      load     = hold_full_q && ((state_q == ST_IDLE) || byte_end);

      hold_full_d = hold_full_q;
      if (load)   hold_full_d = 1'b0;
      if (accept) hold_full_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         hcnt_q      <= '0;
         bit_q       <= '0;
         half_q      <= 1'b0;
         txd_q       <= 1'b1;
         txen_q      <= 1'b0;
`ifdef MX_EOF_EN
         eof_cnt_q   <= '0;
`endif
      end else begin
         hold_full_q <= hold_full_d;
         if (accept) hold_q <= data;

         case (state_q)
            ST_IDLE: begin
               txd_q  <= 1'b1;
               txen_q <= 1'b0;
               if (hold_full_q) begin
                  shift_q <= hold_q;
                  state_q <= ST_SEND;
                  hcnt_q  <= '0;
                  bit_q   <= '0;
                  half_q  <= 1'b0;
               end
            end

            ST_SEND: begin
               // txd lags the counters by one clock: it shows the half-bit
               // the counters were pointing at during the previous cycle.
               txd_q  <= shift_q[bit_q] ^ ~half_q;
               txen_q <= 1'b1;
               if (half_end) begin
                  hcnt_q <= '0;
                  half_q <= ~half_q;
                  // bit index wraps 7 -> 0, ready for a following byte
                  if (half_q) bit_q <= bit_q + 3'd1;
                  if (byte_end) begin
                     if (hold_full_q) begin
                        shift_q <= hold_q;
                     end else begin
`ifdef MX_EOF_EN
                        state_q   <= ST_EOF;
                        eof_cnt_q <= '0;
`else
                        state_q   <= ST_IDLE;
`endif
                     end
                  end
               end else begin
                  hcnt_q <= hcnt_q + 1'b1;
               end
            end

`ifdef MX_EOF_EN
            ST_EOF: begin
               txd_q  <= 1'b1;
               txen_q <= 1'b1;
               if (eof_cnt_q == EOF_LAST) begin
                  state_q   <= ST_IDLE;
                  eof_cnt_q <= '0;
               end else begin
                  eof_cnt_q <= eof_cnt_q + 1'b1;
               end
            end

            default: state_q <= ST_IDLE;
`endif
         endcase
      end
   end

   assign rdy  = ~hold_full_q;
   assign txd  = txd_q;
   assign txen = txen_q;
   assign busy = (state_q != ST_IDLE) || hold_full_q;

endmodule
